// File: rtl/frame_ram_ctrl_pkg.sv
// Shared constants and types for the Sobel-path frame-buffer controller.
package frame_ram_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 100;
  localparam int IMG_H  = 100;
  localparam int DEPTH  = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

  // Frame addresses are free-running and restart at 0 after the last pixel.
  function automatic addr_t addr_inc(input addr_t a);
    return (a == LAST_ADDR) ? '0 : a + addr_t'(1);
  endfunction
endpackage

// File: rtl/frame_ram_ctrl_if.sv
// Pixel-in / pixel-out bus between the source, the frame buffer and the VGA timing side.
interface frame_ram_ctrl_if;
  import frame_ram_ctrl_pkg::*;

  logic   pi_flag;
  pixel_t rgb;
  logic   area2;
  logic   area;
  logic   pix_en;
  pixel_t dout;

  modport master (output pi_flag, rgb, area2, area, pix_en, input dout);
  modport slave  (input pi_flag, rgb, area2, area, pix_en, output dout);
endinterface

// File: rtl/frame_ram_ctrl_sdp_ram.sv
// Simple dual-port RAM, one clock, synchronous read, read-first on address collision.
module sdp_ram
  import frame_ram_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  addr_t  waddr,
  input  pixel_t wdata,
  input  logic   re,
  input  addr_t  raddr,
  output pixel_t rdata
);
  pixel_t mem [DEPTH];

  // Both ports update with non-blocking writes, so a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/frame_ram_ctrl.sv
// Frame buffer: stores strobed pixels inside area2, streams them out at pixel rate inside area.
module frame_ram_ctrl
  import frame_ram_ctrl_pkg::*;
(
  input  logic           sclk,
  input  logic           rst,
  frame_ram_ctrl_if.slave bus
);
  logic   wr_en;
  logic   rd_en;
  addr_t  wr_addr_q, wr_addr_d;
  addr_t  rd_addr_q, rd_addr_d;
  logic   dout_sel_q, dout_sel_d;
  pixel_t ram_rdata;

  assign wr_en = bus.pi_flag & bus.area2;
  assign rd_en = bus.area & bus.pix_en;

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_sel_d = dout_sel_q;
    if (wr_en) wr_addr_d = addr_inc(wr_addr_q);
    if (rd_en) rd_addr_d = addr_inc(rd_addr_q);
    // Outside the display window the output blanks; it unblanks on the first read.
    if (!bus.area)  dout_sel_d = 1'b0;
    else if (rd_en) dout_sel_d = 1'b1;
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_sel_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_sel_q <= dout_sel_d;
    end
  end

  // The RAM has no reset; gating with rst keeps a held reset from writing stray pixels.
  sdp_ram u_ram (
    .clk   (sclk),
    .we    (wr_en & ~rst),
    .waddr (wr_addr_q),
    .wdata (bus.rgb),
    .re    (rd_en & ~rst),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

  assign bus.dout = dout_sel_q ? ram_rdata : '0;
endmodule

// File: tb/tb_frame_ram_ctrl.sv
// Directed plus randomized bench for frame_ram_ctrl with a behavioural frame-store model.
module tb_frame_ram_ctrl;
  import frame_ram_ctrl_pkg::*;

  logic sclk = 1'b0;
  logic rst;
  frame_ram_ctrl_if bus();

  frame_ram_ctrl dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;
  // Model: -1 marks a word never written (its readback is not predicted).
  int m_mem [DEPTH];
  int m_wr   = 0;
  int m_rd   = 0;
  int m_dout = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sclk of stimulus, then advance the model and compare.
  task automatic cycle(input logic pf, input logic [7:0] px, input logic a2,
                       input logic a, input logic pe);
    bus.pi_flag = pf;
    bus.rgb     = px;
    bus.area2   = a2;
    bus.area    = a;
    bus.pix_en  = pe;
    #1;
    chk("wr_en", {31'd0, dut.wr_en}, {31'd0, pf & a2});
    @(posedge sclk);
    if (!a)      m_dout = 0;
    else if (pe) m_dout = m_mem[m_rd];
    if (a && pe) m_rd = (m_rd + 1) % DEPTH;
    if (pf && a2) begin
      m_mem[m_wr] = int'(px);
      m_wr = (m_wr + 1) % DEPTH;
    end
    #1;
    if (m_dout >= 0) chk("dout", {24'd0, bus.dout}, m_dout);
    chk("wr_addr", {18'd0, dut.wr_addr_q}, m_wr);
    chk("rd_addr", {18'd0, dut.rd_addr_q}, m_rd);
  endtask

  // Asynchronous reset in the middle of a cycle, held one edge with busy inputs.
  task automatic do_reset();
    bus.pi_flag = 1'b1;
    bus.rgb     = 8'h99;
    bus.area2   = 1'b1;
    bus.area    = 1'b1;
    bus.pix_en  = 1'b1;
    rst = 1'b1;
    m_wr = 0;
    m_rd = 0;
    m_dout = 0;
    #1;
    chk("rst_dout", {24'd0, bus.dout}, 0);
    chk("rst_rd_addr", {18'd0, dut.rd_addr_q}, 0);
    chk("rst_wr_addr", {18'd0, dut.wr_addr_q}, 0);
    @(posedge sclk);
    #1;
    chk("rst_hold_dout", {24'd0, bus.dout}, 0);
    chk("rst_hold_wr_addr", {18'd0, dut.wr_addr_q}, 0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = -1;
    rst = 1'b1;
    bus.pi_flag = 1'b0;
    bus.rgb     = '0;
    bus.area2   = 1'b0;
    bus.area    = 1'b0;
    bus.pix_en  = 1'b0;
    #12;
    chk("reset_dout", {24'd0, bus.dout}, 0);
    chk("reset_wr_addr", {18'd0, dut.wr_addr_q}, 0);
    chk("reset_rd_addr", {18'd0, dut.rd_addr_q}, 0);
    rst = 1'b0;
    @(posedge sclk);
    #1;

    // Fill the first line: 100 strobes, one every 5 sclk.
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("t1_wr_addr", {18'd0, dut.wr_addr_q}, 100);
    for (int i = 0; i < 100; i++) chk("t1_mem", {24'd0, dut.u_ram.mem[i]}, i);

    // Read 50 pixels at half rate.
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("t2_dout", {24'd0, bus.dout}, i);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("t2_hold", {24'd0, bus.dout}, i);
    end
    chk("t2_rd_addr", {18'd0, dut.rd_addr_q}, 50);

    // Strobes outside the write window are ignored; display blanks.
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'(i % 2));
    chk("t3_blank", {24'd0, bus.dout}, 0);
    chk("t3_wr_addr", {18'd0, dut.wr_addr_q}, 100);
    for (int i = 0; i < 100; i++) chk("t3_mem", {24'd0, dut.u_ram.mem[i]}, i);

    // Same-address read and write: read-first, new word seen one frame later.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i), 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    chk("t5_collision", {24'd0, bus.dout}, 8'h05);
    for (int k = 0; k < DEPTH; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("t5_next_frame", {24'd0, bus.dout}, 8'hEE);

    // Reset mid-read, then reading restarts at address 0 with stored data intact.
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("t6_restart", {24'd0, bus.dout}, (i == 5) ? 8'hEE : 8'(i));
    end

    // Write wrap: DEPTH words of 0x55 then one 0x77 overwrites address 0.
    do_reset();
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("t4_wr_addr", {18'd0, dut.wr_addr_q}, 1);
    chk("t4_mem0", {24'd0, dut.u_ram.mem[0]}, 8'h77);
    chk("t4_mem1", {24'd0, dut.u_ram.mem[1]}, 8'h55);
    chk("t4_mem_last", {24'd0, dut.u_ram.mem[DEPTH-1]}, 8'h55);

    // Random traffic on both ports with occasional asynchronous resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
